median_stream_ctrl: RTL
=======================

// Module: median_stream_ctrl
// PURPOSE
//  Sequences the 3x3 median datapath over a raster-scanned image.
//  - Accepts one pixel per cycle from an upstream stream.
//  - Keeps two line buffers and a 3x3 window register.
//  - Issues interior windows to the median_3x3 core and realigns the core's result with a valid flag.
//  - Runs an IDLE/FILL/RUN/DRAIN state machine per frame and signals frame completion.
//  Sits between the pixel source (memory reader) and the filtered-pixel sink.
// PARAMETERS
//  IMG_W       128  pixels per line; legal range 3..4096
//  IMG_H       128  lines per frame; legal range 3..4096
//  MEDIAN_LAT  1    clk cycles from o_win_valid to i_median being valid (median_3x3 core latency)
//  Pixel width is `PIXEL_WIDTH (parameter.v) and is written PW below.
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active high
//  i_start      in   1      1-cycle pulse; starts a frame; honoured only in IDLE
//  i_valid      in   1      i_pixel is valid this cycle
//  i_pixel      in   PW     raster-order input pixel
//  o_ready      out  1      controller accepts i_pixel; a transfer happens when i_valid & o_ready
//  o_win        out  9*PW   window to the core; p0 is [PW-1:0] ... p8 is [9*PW-1:8*PW]
//  o_win_valid  out  1      o_win holds a complete interior window
//  i_median     in   PW     o_median from the median_3x3 core
//  o_valid      out  1      o_pixel is a filtered pixel
//  o_pixel      out  PW     filtered pixel, raster order, interior pixels only
//  o_busy       out  1      high in every state except IDLE
//  o_done       out  1      1-cycle pulse after the last o_valid of the frame
// BEHAVIOUR
//  Reset (synchronous):
//   - State goes to IDLE; row and column counters clear.
//   - All outputs are 0: o_win, o_win_valid, o_valid, o_pixel, o_busy, o_done, o_ready.
//   - The valid delay line clears. Line-buffer contents are don't-care.
//  FSM:
//   - IDLE -> FILL on i_start. o_ready=1 in FILL and RUN only.
//   - FILL: accepts rows 0..1 into the line buffers. Moves to RUN after the last pixel of row 1.
//   - RUN: accepts rows 2..IMG_H-1. Moves to DRAIN after pixel (IMG_H-1, IMG_W-1) is accepted.
//   - DRAIN: o_ready=0. Waits until the valid delay line is empty (MEDIAN_LAT+1 cycles), then
//     pulses o_done for 1 cycle and returns to IDLE.
//  Counters:
//   - col wraps IMG_W-1 -> 0 and increments row. Both advance only on an accepted transfer.
//   - i_valid=0 stalls the frame with no side effects.
//  Window:
//   - Each accepted pixel shifts the 3x3 window left by one column.
//   - New right column, top to bottom: linebuf1[col], linebuf0[col], i_pixel.
//   - Then linebuf1[col]<=linebuf0[col] and linebuf0[col]<=i_pixel.
//   - p0..p2 is the oldest row and p6..p8 the current row; left to right is oldest to newest column.
//  Window issue:
//   - When the transfer has row>=2 and col>=2, o_win and o_win_valid=1 are registered 1 cycle later.
//   - Otherwise o_win_valid=0 on the next cycle and o_win holds its value.
//   - Windows never span a line wrap (col>=2 guard).
//  Output:
//   - o_valid is o_win_valid delayed MEDIAN_LAT cycles; o_pixel=i_median on those cycles.
//   - Output latency is 1+MEDIAN_LAT cycles after the accepting edge.
//   - Outputs per frame: exactly (IMG_W-2)*(IMG_H-2). Border pixels produce no output.
//  Output flow control:
//   - There is no output back-pressure; the sink must accept every o_valid.
//   - The output pixel counter compares against (IMG_W-2)*(IMG_H-2). A mismatch in DRAIN is a
//     design error and is flagged in simulation only ($error).
//  Edge cases:
//   - i_start outside IDLE is ignored.
//   - i_valid in IDLE or DRAIN is not accepted (o_ready=0).
//   - rst in any state aborts the frame at the next edge; partial outputs are discarded; no o_done.
//   - A new i_start is legal in the same cycle o_done is high (FSM is back in IDLE next edge).
// TESTING
//  1. 3x3 frame, pixels 1..9, continuous i_valid -> exactly one o_valid, o_pixel=5, then o_done.
//  2. 3x3 frame 10,1,30,50,90,20,150,40,5 -> o_pixel=30; window 0,0,255,255,100,0,255,0,255 -> 100.
//  3. 5x4 frame, value=row*5+col -> 6 outputs = 6,7,8,11,12,13; no o_valid at col<2 or row<2.
//  4. Frame 3 with i_valid toggled randomly 50% -> same outputs and order as continuous input;
//     counters frozen while i_valid=0.
//  5. rst asserted mid-RUN -> next cycle all outputs 0, state IDLE; a following clean frame is correct.
//  6. i_start during RUN -> ignored; i_start on the o_done cycle -> second frame runs correctly.

Source files
------------

// File: rtl/median_stream_ctrl.sv
// median_stream_ctrl
//   Frame sequencer for a 3x3 median filter over a raster-scanned image.
//   Pixels arrive one per accepted transfer. Two line buffers and a 3x3 shift
//   window build each neighbourhood. Every interior window is handed to an
//   external median_3x3 core, and the core's result is realigned with a valid
//   flag. An IDLE/FILL/RUN/DRAIN FSM runs once per frame and pulses o_done
//   after the last filtered pixel.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   i_start       frame start pulse, honoured only in IDLE
//   i_valid       i_pixel is valid this cycle
//   i_pixel       raster-order input pixel
//   o_ready       a transfer happens when i_valid & o_ready (FILL/RUN only)
//   o_win         window to the core, p0 = [DATA_W-1:0] ... p8 = top slice
//   o_win_valid   o_win holds a complete interior window
//   i_median      result from the median core, MEDIAN_LAT cycles after o_win_valid
//   o_valid       o_pixel carries a filtered interior pixel
//   o_pixel       filtered pixel, zero when o_valid is low
//   o_busy        high in every state except IDLE
//   o_done        one-cycle pulse after the last o_valid of the frame
module median_stream_ctrl #(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int MEDIAN_LAT = 1,
  parameter int DATA_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic [DATA_W-1:0]   i_pixel,
  output logic                o_ready,
  output logic [9*DATA_W-1:0] o_win,
  output logic                o_win_valid,
  input  logic [DATA_W-1:0]   i_median,
  output logic                o_valid,
  output logic [DATA_W-1:0]   o_pixel,
  output logic                o_busy,
  output logic                o_done
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int DW    = $clog2(MEDIAN_LAT + 1);
  localparam int OUT_N = (IMG_W - 2) * (IMG_H - 2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DW-1:0]         drain_cnt;
  logic [31:0]           out_cnt;
  logic                  accept, last_col, last_row, issue, done_nxt;

  logic [DATA_W-1:0]     lb0 [IMG_W];
  logic [DATA_W-1:0]     lb1 [IMG_W];
  logic [DATA_W-1:0]     win_p0  [9];
  logic [DATA_W-1:0]     win_nxt [9];
  logic [MEDIAN_LAT-1:0] vld_p2;

  always_comb begin
    o_ready  = (state == FILL) || (state == RUN);
    o_busy   = (state != IDLE);
    accept   = i_valid && o_ready;
    last_col = (col == CW'(IMG_W - 1));
    last_row = (row == RW'(IMG_H - 1));
    // Only windows whose three columns all lie on the current row set are
    // interior; the col guard keeps a window from straddling a line wrap.
    issue    = accept && (row >= RW'(2)) && (col >= CW'(2));
    o_valid  = vld_p2[MEDIAN_LAT-1];
    o_pixel  = o_valid ? i_median : '0;
  end

  // Window after this pixel: shift left, new right column is
  // oldest line, previous line, current pixel.
  always_comb begin
    win_nxt[0] = win_p0[1];
    win_nxt[1] = win_p0[2];
    win_nxt[2] = lb1[col];
    win_nxt[3] = win_p0[4];
    win_nxt[4] = win_p0[5];
    win_nxt[5] = lb0[col];
    win_nxt[6] = win_p0[7];
    win_nxt[7] = win_p0[8];
    win_nxt[8] = i_pixel;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (i_start) state_nxt = FILL;
      FILL:  if (accept && (row == RW'(1)) && last_col) state_nxt = RUN;
      RUN:   if (accept && last_row && last_col) state_nxt = DRAIN;
      DRAIN: begin
        // The last window was issued on the cycle DRAIN was entered; its
        // result leaves the delay line MEDIAN_LAT cycles later.
        if (drain_cnt == DW'(MEDIAN_LAT)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0 -> p1: control, counters, window issue, valid delay line ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      drain_cnt   <= '0;
      out_cnt     <= '0;
      o_done      <= 1'b0;
      o_win_valid <= 1'b0;
      o_win       <= '0;
      vld_p2      <= '0;
    end else begin
      state       <= state_nxt;
      o_done      <= done_nxt;
      o_win_valid <= issue;
      vld_p2[0]   <= o_win_valid;
      for (int k = 1; k < MEDIAN_LAT; k++) vld_p2[k] <= vld_p2[k-1];

      if (issue)
        for (int k = 0; k < 9; k++) o_win[k*DATA_W +: DATA_W] <= win_nxt[k];

      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;

      if (state == IDLE && i_start) begin
        row     <= '0;
        col     <= '0;
        out_cnt <= '0;
      end else begin
        if (o_valid) out_cnt <= out_cnt + 32'd1;
        if (accept) begin
          if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
      end
    end
  end

  // ---- stage p0: line buffers and shift window (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 9; k++) win_p0[k] <= win_nxt[k];
      lb1[col] <= lb0[col];
      lb0[col] <= i_pixel;
    end
  end

`ifndef SYNTHESIS
  // The output count must equal the interior pixel count when the frame closes.
  always_ff @(posedge clk) begin
    if (!rst && state == DRAIN && state_nxt == IDLE &&
        (out_cnt + 32'(o_valid)) != 32'(OUT_N))
      $error("median_stream_ctrl: %0d outputs in frame, expected %0d",
             out_cnt + 32'(o_valid), OUT_N);
  end
`endif

endmodule
